// File: rtl/zx_bus_sequencer.sv
// ============================================================================
// zx_bus_sequencer
//   Stalls the Z80 on serviced ROM/IO cycles, posts a request word to the
//   SPI shifter, returns the Pi's response byte and then releases the bus.
//   Rev 1.0
// ============================================================================
`default_nettype none

module zx_bus_sequencer #(
  parameter logic [7:0] IO_BASE        = 8'h3B,
  parameter logic [7:0] IO_MASK        = 8'hFF,
  parameter logic [7:0] RSP_TAG        = 8'h40,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        PI_MASTER_CLK,
  input  logic        PI_RESET_n,
  input  logic [15:0] ZX_ADDR,
  input  logic        ZX_M1_n,
  input  logic        ZX_MREQ_n,
  input  logic        ZX_IORQ_n,
  input  logic        ZX_RD_n,
  input  logic        ZX_WR_n,
  input  logic [7:0]  ZX_DATA_IN,
  input  logic        ROMCS_EN,
  output logic        ZX_WAIT_n,
  output logic [7:0]  ZX_DATA_OUT,
  output logic        ZX_DATA_OE,
  output logic [15:0] TX_WORD,
  output logic        TX_VALID,
  input  logic        TX_READY,
  input  logic [15:0] RX_WORD,
  input  logic        RX_VALID,
  output logic        BUSY,
  output logic        TIMEOUT_ERR
);

  localparam int                   c_TIMER_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RSP     = 3'd2,
    S_DRIVE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t               r_state, w_state_nx;
  logic [4:0]           r_sync1, r_sync2;
  logic                 r_wait_n, w_wait_n_nx;
  logic                 r_oe, w_oe_nx;
  logic [7:0]           r_data_out, w_data_out_nx;
  logic                 r_tx_valid, w_tx_valid_nx;
  logic [15:0]          r_tx_word, w_tx_word_nx;
  logic                 r_timeout_err, w_timeout_err_nx;
  logic [c_TIMER_W-1:0] r_timer, w_timer_nx;
  logic                 r_is_read, w_is_read_nx;

  logic w_m1_n, w_mreq_n, w_iorq_n, w_rd_n, w_wr_n;
  logic w_io_hit, w_mem_rd, w_io_rd, w_io_wr, w_abort, w_bus_idle;

  // Strobe synchronisers, bit order {M1, MREQ, IORQ, RD, WR}
  always_ff @(posedge PI_MASTER_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      r_sync1 <= 5'h1F;
      r_sync2 <= 5'h1F;
    end else begin
      r_sync1 <= {ZX_M1_n, ZX_MREQ_n, ZX_IORQ_n, ZX_RD_n, ZX_WR_n};
      r_sync2 <= r_sync1;
    end
  end

  assign w_m1_n   = r_sync2[4];
  assign w_mreq_n = r_sync2[3];
  assign w_iorq_n = r_sync2[2];
  assign w_rd_n   = r_sync2[1];
  assign w_wr_n   = r_sync2[0];

  assign w_io_hit   = (ZX_ADDR[7:0] & IO_MASK) == (IO_BASE & IO_MASK);
  assign w_mem_rd   = !w_mreq_n && !w_rd_n && ROMCS_EN && (ZX_ADDR[15:14] == 2'b00);
  assign w_io_rd    = !w_iorq_n && !w_rd_n && w_m1_n && w_io_hit;
  assign w_io_wr    = !w_iorq_n && !w_wr_n && w_m1_n && w_io_hit;
  assign w_abort    = w_mreq_n && w_iorq_n;
  assign w_bus_idle = w_mreq_n && w_iorq_n && w_rd_n && w_wr_n;

  always_comb begin
    w_state_nx       = r_state;
    w_wait_n_nx      = r_wait_n;
    w_oe_nx          = r_oe;
    w_data_out_nx    = r_data_out;
    w_tx_valid_nx    = r_tx_valid;
    w_tx_word_nx     = r_tx_word;
    w_timeout_err_nx = 1'b0;
    w_timer_nx       = r_timer;
    w_is_read_nx     = r_is_read;

    case (r_state)
      S_IDLE: begin
        if (w_mem_rd || w_io_rd || w_io_wr) begin
          w_wait_n_nx   = 1'b0;
          w_tx_valid_nx = 1'b1;
          w_is_read_nx  = w_mem_rd || w_io_rd;
          w_state_nx    = S_REQ;
          if (w_mem_rd)
            w_tx_word_nx = {2'b00, ZX_ADDR[13:0]};
          else if (w_io_rd)
            w_tx_word_nx = {2'b01, 6'b000000, ZX_ADDR[7:0]};
          else
            w_tx_word_nx = {2'b10, ZX_ADDR[5:0], ZX_DATA_IN};
        end
      end

      S_REQ: begin
        if (w_abort) begin
          w_wait_n_nx   = 1'b1;
          w_oe_nx       = 1'b0;
          w_tx_valid_nx = 1'b0;
          w_state_nx    = S_IDLE;
        end else if (TX_READY) begin
          // A coincident RX_VALID belongs to an earlier frame, not this request
          w_tx_valid_nx = 1'b0;
          if (r_is_read) begin
            w_timer_nx = '0;
            w_state_nx = S_RSP;
          end else begin
            w_wait_n_nx = 1'b1;
            w_state_nx  = S_RELEASE;
          end
        end
      end

      S_RSP: begin
        if (w_abort) begin
          w_wait_n_nx = 1'b1;
          w_oe_nx     = 1'b0;
          w_state_nx  = S_IDLE;
        end else if (RX_VALID && (RX_WORD[15:8] == RSP_TAG)) begin
          w_data_out_nx = RX_WORD[7:0];
          w_oe_nx       = 1'b1;
          w_state_nx    = S_DRIVE;
        end else if (r_timer == c_TIMER_LAST) begin
          w_data_out_nx    = 8'hFF;
          w_oe_nx          = 1'b1;
          w_timeout_err_nx = 1'b1;
          w_state_nx       = S_DRIVE;
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end

      S_DRIVE: begin
        w_oe_nx     = 1'b1;
        w_wait_n_nx = 1'b1;
        w_state_nx  = S_RELEASE;
      end

      S_RELEASE: begin
        w_wait_n_nx = 1'b1;
        if (w_rd_n)
          w_oe_nx = 1'b0;
        if (w_bus_idle) begin
          w_oe_nx    = 1'b0;
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_wait_n_nx   = 1'b1;
        w_oe_nx       = 1'b0;
        w_tx_valid_nx = 1'b0;
        w_state_nx    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PI_MASTER_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      r_state       <= S_IDLE;
      r_wait_n      <= 1'b1;
      r_oe          <= 1'b0;
      r_data_out    <= 8'hFF;
      r_tx_valid    <= 1'b0;
      r_tx_word     <= 16'h0000;
      r_timeout_err <= 1'b0;
      r_timer       <= '0;
      r_is_read     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_wait_n      <= w_wait_n_nx;
      r_oe          <= w_oe_nx;
      r_data_out    <= w_data_out_nx;
      r_tx_valid    <= w_tx_valid_nx;
      r_tx_word     <= w_tx_word_nx;
      r_timeout_err <= w_timeout_err_nx;
      r_timer       <= w_timer_nx;
      r_is_read     <= w_is_read_nx;
    end
  end

  assign ZX_WAIT_n   = r_wait_n;
  assign ZX_DATA_OE  = r_oe;
  assign ZX_DATA_OUT = r_data_out;
  assign TX_VALID    = r_tx_valid;
  assign TX_WORD     = r_tx_word;
  assign TIMEOUT_ERR = r_timeout_err;
  assign BUSY        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_zx_bus_sequencer.sv
// ============================================================================
// tb_zx_bus_sequencer
//   Directed self-checking bench for zx_bus_sequencer.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_zx_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic [7:0]  data_in;
  logic        romcs_en;
  logic        wait_n;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  zx_bus_sequencer dut (
    .PI_MASTER_CLK (clk),
    .PI_RESET_n    (rst_n),
    .ZX_ADDR       (addr),
    .ZX_M1_n       (m1_n),
    .ZX_MREQ_n     (mreq_n),
    .ZX_IORQ_n     (iorq_n),
    .ZX_RD_n       (rd_n),
    .ZX_WR_n       (wr_n),
    .ZX_DATA_IN    (data_in),
    .ROMCS_EN      (romcs_en),
    .ZX_WAIT_n     (wait_n),
    .ZX_DATA_OUT   (data_out),
    .ZX_DATA_OE    (data_oe),
    .TX_WORD       (tx_word),
    .TX_VALID      (tx_valid),
    .TX_READY      (tx_ready),
    .RX_WORD       (rx_word),
    .RX_VALID      (rx_valid),
    .BUSY          (busy),
    .TIMEOUT_ERR   (timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic pulse_rx(input logic [15:0] w);
    rx_word = w; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic accept_tx();
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_idle();
    tick(2);
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL rst_wait actual=%h expected=1", wait_n); end
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL rst_oe actual=%h expected=0", data_oe); end
    n_checks++; if (data_out !== 8'hFF)   begin n_fail++; $display("FAIL rst_data actual=%h expected=ff", data_out); end
    n_checks++; if (tx_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_txv actual=%h expected=0", tx_valid); end
    n_checks++; if (tx_word !== 16'h0000) begin n_fail++; $display("FAIL rst_txw actual=%h expected=0000", tx_word); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy actual=%h expected=0", busy); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr actual=%h expected=0", timeout_err); end
    rst_n = 1'b1;
    tick(3);
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL post_rst_busy actual=%h expected=0", busy); end
  endtask

  task automatic test_m1_fetch();
    addr = 16'h0000; romcs_en = 1'b1;
    m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    tick(2);
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL m1_wait_early actual=%h expected=1", wait_n); end
    tick(1);
    n_checks++; if (wait_n !== 1'b0)      begin n_fail++; $display("FAIL m1_wait_low actual=%h expected=0", wait_n); end
    n_checks++; if (tx_valid !== 1'b1)    begin n_fail++; $display("FAIL m1_txv actual=%h expected=1", tx_valid); end
    n_checks++; if (tx_word !== 16'h0000) begin n_fail++; $display("FAIL m1_txw actual=%h expected=0000", tx_word); end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL m1_busy actual=%h expected=1", busy); end
    accept_tx();
    n_checks++; if (tx_valid !== 1'b0)    begin n_fail++; $display("FAIL m1_txv_drop actual=%h expected=0", tx_valid); end
    tick(19);
    n_checks++; if (wait_n !== 1'b0)      begin n_fail++; $display("FAIL m1_wait_hold actual=%h expected=0", wait_n); end
    pulse_rx(16'h40F3);
    n_checks++; if (data_out !== 8'hF3)   begin n_fail++; $display("FAIL m1_data actual=%h expected=f3", data_out); end
    n_checks++; if (data_oe !== 1'b1)     begin n_fail++; $display("FAIL m1_oe actual=%h expected=1", data_oe); end
    tick(1);
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL m1_wait_rel actual=%h expected=1", wait_n); end
    tick(2);
    n_checks++; if (data_oe !== 1'b1)     begin n_fail++; $display("FAIL m1_oe_hold actual=%h expected=1", data_oe); end
    bus_idle();
    tick(2);
    n_checks++; if (data_oe !== 1'b1)     begin n_fail++; $display("FAIL m1_oe_sync actual=%h expected=1", data_oe); end
    tick(1);
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL m1_oe_drop actual=%h expected=0", data_oe); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL m1_idle actual=%h expected=0", busy); end
  endtask

  task automatic test_nmi_fetch();
    addr = 16'h0066; romcs_en = 1'b1;
    m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    n_checks++; if (tx_word !== 16'h0066) begin n_fail++; $display("FAIL nmi_txw actual=%h expected=0066", tx_word); end
    tick(10);
    n_checks++; if (tx_valid !== 1'b1)    begin n_fail++; $display("FAIL nmi_txv_hold actual=%h expected=1", tx_valid); end
    accept_tx();
    tick(2);
    pulse_rx(16'h1234);
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL nmi_badtag_oe actual=%h expected=0", data_oe); end
    n_checks++; if (wait_n !== 1'b0)      begin n_fail++; $display("FAIL nmi_badtag_wait actual=%h expected=0", wait_n); end
    tick(5);
    pulse_rx(16'h40BD);
    n_checks++; if (data_out !== 8'hBD)   begin n_fail++; $display("FAIL nmi_data actual=%h expected=bd", data_out); end
    n_checks++; if (data_oe !== 1'b1)     begin n_fail++; $display("FAIL nmi_oe actual=%h expected=1", data_oe); end
    tick(1);
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL nmi_wait_rel actual=%h expected=1", wait_n); end
    bus_idle();
    tick(3);
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL nmi_idle actual=%h expected=0", busy); end
  endtask

  task automatic test_io_write();
    addr = 16'h003B; data_in = 8'hA5;
    iorq_n = 1'b0; wr_n = 1'b0;
    tick(3);
    n_checks++; if (tx_word !== 16'hBBA5) begin n_fail++; $display("FAIL iow_txw actual=%h expected=bba5", tx_word); end
    n_checks++; if (wait_n !== 1'b0)      begin n_fail++; $display("FAIL iow_wait actual=%h expected=0", wait_n); end
    accept_tx();
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL iow_wait_rel actual=%h expected=1", wait_n); end
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL iow_oe actual=%h expected=0", data_oe); end
    tick(6);
    n_checks++; if (tx_valid !== 1'b0)    begin n_fail++; $display("FAIL iow_no_repeat actual=%h expected=0", tx_valid); end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL iow_busy_hold actual=%h expected=1", busy); end
    bus_idle();
    tick(3);
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL iow_idle actual=%h expected=0", busy); end
  endtask

  task automatic test_io_read_timeout();
    int seen_at;
    seen_at = -1;
    addr = 16'h003B;
    iorq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    n_checks++; if (tx_word !== 16'h403B) begin n_fail++; $display("FAIL ior_txw actual=%h expected=403b", tx_word); end
    accept_tx();
    for (int i = 1; i <= 4200; i++) begin
      tick(1);
      if (timeout_err === 1'b1) begin
        seen_at = i;
        break;
      end
    end
    n_checks++; if (seen_at != 4096)      begin n_fail++; $display("FAIL ior_timeout_cycle actual=%0d expected=4096", seen_at); end
    n_checks++; if (data_out !== 8'hFF)   begin n_fail++; $display("FAIL ior_timeout_data actual=%h expected=ff", data_out); end
    n_checks++; if (data_oe !== 1'b1)     begin n_fail++; $display("FAIL ior_timeout_oe actual=%h expected=1", data_oe); end
    tick(1);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL ior_terr_pulse actual=%h expected=0", timeout_err); end
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL ior_wait_rel actual=%h expected=1", wait_n); end
    bus_idle();
    tick(3);
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL ior_idle actual=%h expected=0", busy); end
  endtask

  task automatic test_ignored();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin addr = 16'h0000; romcs_en = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
        1: begin addr = 16'h8000; romcs_en = 1'b1; mreq_n = 1'b0; rd_n = 1'b0; end
        default: begin addr = 16'h003B; romcs_en = 1'b1; m1_n = 1'b0; iorq_n = 1'b0; end
      endcase
      tick(6);
      n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL ign%0d_txv actual=%h expected=0", k, tx_valid); end
      n_checks++; if (wait_n !== 1'b1)    begin n_fail++; $display("FAIL ign%0d_wait actual=%h expected=1", k, wait_n); end
      bus_idle();
      tick(3);
    end
    romcs_en = 1'b1;
  endtask

  task automatic test_ready_rx_same_cycle();
    addr = 16'h0001;
    mreq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    n_checks++; if (tx_word !== 16'h0001) begin n_fail++; $display("FAIL same_txw actual=%h expected=0001", tx_word); end
    tx_ready = 1'b1; rx_word = 16'h40F3; rx_valid = 1'b1;
    tick(1);
    tx_ready = 1'b0; rx_valid = 1'b0;
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL same_oe actual=%h expected=0", data_oe); end
    n_checks++; if (wait_n !== 1'b0)      begin n_fail++; $display("FAIL same_wait actual=%h expected=0", wait_n); end
    tick(2);
    pulse_rx(16'h4077);
    n_checks++; if (data_out !== 8'h77)   begin n_fail++; $display("FAIL same_data actual=%h expected=77", data_out); end
    tick(1);
    bus_idle();
    tick(3);
  endtask

  task automatic test_abort();
    // reset while waiting for a response
    addr = 16'h0000;
    mreq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    accept_tx();
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL rstmid_busy_pre actual=%h expected=1", busy); end
    rst_n = 1'b0;
    bus_idle();
    #1;
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL rstmid_wait actual=%h expected=1", wait_n); end
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL rstmid_oe actual=%h expected=0", data_oe); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rstmid_busy actual=%h expected=0", busy); end
    tick(1);
    rst_n = 1'b1;
    tick(3);
    pulse_rx(16'h40F3);
    tick(1);
    n_checks++; if (data_out !== 8'hFF)   begin n_fail++; $display("FAIL rstmid_late_data actual=%h expected=ff", data_out); end
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL rstmid_late_oe actual=%h expected=0", data_oe); end

    // Z80 drops its strobes while waiting for a response
    mreq_n = 1'b0; rd_n = 1'b0;
    tick(3);
    accept_tx();
    bus_idle();
    tick(3);
    n_checks++; if (wait_n !== 1'b1)      begin n_fail++; $display("FAIL abort_wait actual=%h expected=1", wait_n); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL abort_busy actual=%h expected=0", busy); end
    pulse_rx(16'h40F3);
    tick(1);
    n_checks++; if (data_out !== 8'hFF)   begin n_fail++; $display("FAIL abort_late_data actual=%h expected=ff", data_out); end
    n_checks++; if (data_oe !== 1'b0)     begin n_fail++; $display("FAIL abort_late_oe actual=%h expected=0", data_oe); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL abort_late_busy actual=%h expected=0", busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 16'h0000; data_in = 8'h00; romcs_en = 1'b1;
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    tx_ready = 1'b0; rx_word = 16'h0000; rx_valid = 1'b0;

    test_reset();
    test_m1_fetch();
    test_nmi_fetch();
    test_io_write();
    test_io_read_timeout();
    test_ignored();
    test_ready_rx_same_cycle();
    test_abort();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
